// File: rtl/arm_pkg.sv
// Shared ARM status-flag definitions: data-processing opcodes, condition
// codes, flag-update FSM states and NZCV bit positions in the PSR.
package arm_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } flag_state_e;

  // Flag positions inside the 32-bit PSR.
  localparam int FLAG_N = 31;
  localparam int FLAG_Z = 30;
  localparam int FLAG_C = 29;
  localparam int FLAG_V = 28;

  // Same positions inside a packed 4-bit NZCV nibble.
  localparam int NZCV_N = FLAG_N - FLAG_V;
  localparam int NZCV_Z = FLAG_Z - FLAG_V;
  localparam int NZCV_C = FLAG_C - FLAG_V;
  localparam int NZCV_V = 0;

  // Adder-based opcodes take C/V from the adder; the rest take C from the shifter.
  function automatic logic is_arith_op(input logic [3:0] op);
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC,
      OP_SBC, OP_RSC, OP_CMP, OP_CMN: is_arith_op = 1'b1;
      default:                        is_arith_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator; shared with the branch unit.
module cond_eval
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  // Decode the 4-bit condition field against the supplied flags.
  always_comb begin
    n    = nzcv[NZCV_N];
    z    = nzcv[NZCV_Z];
    c    = nzcv[NZCV_C];
    v    = nzcv[NZCV_V];
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_update_unit.sv
// Flag update unit: stages NZCV from an ALU result or an MSR write for one
// cycle, drives the status register load (active-low LE), and forwards the
// staged flags to condition evaluation so a dependent instruction sees them
// before the register commits on the falling edge.
module flag_update_unit
  import arm_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        alu_valid,
  input  logic        alu_s,
  input  logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_ovf,
  input  logic        shf_cout,
  output logic        alu_ready,
  input  logic        msr_valid,
  input  logic [3:0]  msr_flags,
  input  logic [31:0] psr_q,
  input  logic [3:0]  cond,
  output logic [31:0] psr_d,
  output logic        psr_le,
  output logic        cond_pass
);

  flag_state_e state_q, state_d;
  logic [3:0]  nzcv_q, nzcv_d;
  logic [3:0]  fwd_nzcv;
  logic [3:0]  alu_nzcv;
  logic        pend;

  assign pend      = (state_q == ST_PEND);
  // MSR has priority; the ALU producer holds its request while blocked.
  assign alu_ready = !msr_valid;

  // Forward staged flags, build ALU flags, and choose the next staged value.
  always_comb begin
    fwd_nzcv = pend ? nzcv_q : psr_q[FLAG_N:FLAG_V];
    alu_nzcv = { alu_result[31],
                 (alu_result == 32'd0),
                 is_arith_op(alu_op) ? alu_cout : shf_cout,
                 is_arith_op(alu_op) ? alu_ovf  : fwd_nzcv[NZCV_V] };
    state_d  = ST_IDLE;
    nzcv_d   = nzcv_q;
    if (msr_valid) begin
      state_d = ST_PEND;
      nzcv_d  = msr_flags;
    end else if (alu_valid && alu_s) begin
      state_d = ST_PEND;
      nzcv_d  = alu_nzcv;
    end
  end

  // State and staged flags; reset cancels any pending commit at once.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= ST_IDLE;
      nzcv_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      nzcv_q  <= nzcv_d;
    end
  end

  // Status register write port: load only during the single PEND cycle.
  always_comb begin
    psr_le = !pend;
    psr_d  = pend ? {nzcv_q, psr_q[FLAG_V-1:0]} : 32'd0;
  end

  cond_eval u_cond_eval (
    .cond (cond),
    .nzcv (fwd_nzcv),
    .pass (cond_pass)
  );

endmodule

// File: tb/tb_flag_update_unit.sv
// Self-checking bench for flag_update_unit: directed vectors, a flag model
// compared every falling edge, and hand-computed literal checks.
module tb_flag_update_unit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        alu_valid, alu_s, alu_cout, alu_ovf, shf_cout;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        msr_valid;
  logic [3:0]  msr_flags;
  logic [31:0] psr_q;
  logic [3:0]  cond;
  logic [31:0] psr_d;
  logic        psr_le;
  logic        cond_pass;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: is a commit owed next cycle, and with which flags.
  logic       m_pend;
  logic [3:0] m_flags;

  flag_update_unit dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .alu_valid  (alu_valid),
    .alu_s      (alu_s),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_ovf    (alu_ovf),
    .shf_cout   (shf_cout),
    .alu_ready  (alu_ready),
    .msr_valid  (msr_valid),
    .msr_flags  (msr_flags),
    .psr_q      (psr_q),
    .cond       (cond),
    .psr_d      (psr_d),
    .psr_le     (psr_le),
    .cond_pass  (cond_pass)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cc_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] flags_of(input logic [3:0] op, input logic [31:0] res,
                                          input logic cout, input logic ovf,
                                          input logic shc, input logic vcur);
    logic arith;
    arith = op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11};
    return {res[31], res == 32'd0, arith ? cout : shc, arith ? ovf : vcur};
  endfunction

  // Model update: each accepted flag write owes exactly one commit next cycle.
  always @(posedge CLK or negedge CLR) begin
    logic [3:0] cur;
    if (!CLR) begin
      m_pend  = 1'b0;
      m_flags = 4'b0000;
    end else begin
      cur = m_pend ? m_flags : psr_q[31:28];
      if (msr_valid) begin
        m_pend  = 1'b1;
        m_flags = msr_flags;
      end else if (alu_valid && alu_s) begin
        m_pend  = 1'b1;
        m_flags = flags_of(alu_op, alu_result, alu_cout, alu_ovf, shf_cout, cur[0]);
      end else begin
        m_pend  = 1'b0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    logic [3:0] cur;
    cur = m_pend ? m_flags : psr_q[31:28];
    chk1 ("mdl_le",    psr_le,    !m_pend);
    chk32("mdl_psr_d", psr_d,     m_pend ? {m_flags, psr_q[27:0]} : 32'd0);
    chk1 ("mdl_ready", alu_ready, !msr_valid);
    chk1 ("mdl_cond",  cond_pass, cc_ok(cond, cur));
  end

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_s = 1'b0; alu_op = 4'd0; alu_result = 32'd0;
    alu_cout = 1'b0; alu_ovf = 1'b0; shf_cout = 1'b0;
    msr_valid = 1'b0; msr_flags = 4'd0;
  endtask

  task automatic alu_req(input logic [3:0] op, input logic s, input logic [31:0] res,
                         input logic cout, input logic ovf, input logic shc);
    alu_valid = 1'b1; alu_s = s; alu_op = op; alu_result = res;
    alu_cout = cout; alu_ovf = ovf; shf_cout = shc;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        shc;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] fpat[6];

  initial begin
    CLR = 1'b0; psr_q = 32'd0; cond = 4'hE;
    idle_inputs();

    // Reset: outputs forced, alu_ready still follows msr_valid, requests ignored.
    msr_valid = 1'b1; msr_flags = 4'hF;
    #12;
    chk1 ("rst_le",      psr_le,    1'b1);
    chk32("rst_psr_d",   psr_d,     32'd0);
    chk1 ("rst_ready0",  alu_ready, 1'b0);
    alu_req(4'd4, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    #10;
    chk1 ("rst_le_hold", psr_le,    1'b1);
    msr_valid = 1'b0;
    #1;
    chk1 ("rst_ready1",  alu_ready, 1'b1);
    idle_inputs();
    @(negedge CLK); #2; CLR = 1'b1;

    // ADD to zero with carry -> 0110, one-cycle load pulse.
    tick();
    psr_q = 32'h0000_00AB;
    alu_req(4'd4, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk1 ("add_pre_le", psr_le, 1'b1);
    tick(); idle_inputs();
    @(negedge CLK);
    chk1 ("add_le",    psr_le,  1'b0);
    chk32("add_psr_d", psr_d,   32'h6000_00AB);
    chk32("add_model", {28'd0, m_flags}, 32'h0000_0006);
    tick();
    @(negedge CLK);
    chk1 ("add_post_le", psr_le, 1'b1);

    // AND negative, shifter carry, V kept from PSR -> 1011.
    tick();
    psr_q = 32'h1000_0000;
    alu_req(4'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    tick(); idle_inputs();
    @(negedge CLK);
    chk1 ("and_le",    psr_le, 1'b0);
    chk32("and_psr_d", psr_d,  32'hB000_0000);
    chk32("and_model", {28'd0, m_flags}, 32'h0000_000B);

    // MSR and SUB together: MSR first, ALU next cycle, two load cycles.
    tick();
    psr_q = 32'd0;
    msr_valid = 1'b1; msr_flags = 4'b0001;
    alu_req(4'd2, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk1 ("col_ready", alu_ready, 1'b0);
    tick(); msr_valid = 1'b0;
    @(negedge CLK);
    chk1 ("col_le1",    psr_le,    1'b0);
    chk32("col_psr_d1", psr_d,     32'h1000_0000);
    chk1 ("col_ready1", alu_ready, 1'b1);
    tick(); idle_inputs();
    @(negedge CLK);
    chk1 ("col_le2",    psr_le, 1'b0);
    chk32("col_psr_d2", psr_d,  32'h2000_0000);
    tick();
    @(negedge CLK);
    chk1 ("col_le3", psr_le, 1'b1);

    // Forwarding: staged Z=1 seen by EQ while PSR Z=0.
    tick();
    psr_q = 32'd0; cond = 4'h0;
    @(negedge CLK);
    chk1 ("fwd_idle_eq", cond_pass, 1'b0);
    tick();
    alu_req(4'd10, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle_inputs();
    @(negedge CLK);
    chk1 ("fwd_eq", cond_pass, 1'b1);
    cond = 4'hF; #1;
    chk1 ("fwd_nv", cond_pass, 1'b0);
    cond = 4'h0;

    // S=0 request: no load, state stays IDLE (EQ reads PSR Z=0, not staged Z=1).
    tick();
    alu_req(4'd4, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk1 ("s0_le_a", psr_le, 1'b1);
    tick();
    @(negedge CLK);
    chk1 ("s0_le_b", psr_le,    1'b1);
    chk1 ("s0_idle", cond_pass, 1'b0);
    idle_inputs();

    // Reset during PEND cancels the commit immediately and for good.
    tick();
    psr_q = 32'hFFFF_FFFF;
    alu_req(4'd4, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle_inputs();
    #2; CLR = 1'b0; #1;
    chk1 ("rp_le",    psr_le, 1'b1);
    chk32("rp_psr_d", psr_d,  32'd0);
    @(negedge CLK); #2; CLR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk1("rp_no_commit", psr_le, 1'b1);
    end

    // Back-to-back ALU updates (PEND -> PEND), cond swept along the way.
    vecs[0] = '{4'd4,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'd13, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{4'd2,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'd15, 32'h8000_0001, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'd11, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4'd1,  32'h0000_0010, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'd7,  32'h8000_0000, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{4'd12, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    psr_q = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      tick();
      alu_req(vecs[i].op, 1'b1, vecs[i].res, vecs[i].cout, vecs[i].ovf, vecs[i].shc);
      cond = 4'(i * 2 + 1);
    end
    tick(); idle_inputs();
    tick();

    // Condition sweep from the PSR in IDLE.
    fpat[0] = 4'h0; fpat[1] = 4'h5; fpat[2] = 4'hA;
    fpat[3] = 4'hF; fpat[4] = 4'h3; fpat[5] = 4'h9;
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 16; c++) begin
        tick();
        psr_q = {fpat[f], 28'h0ABC_DEF};
        cond  = 4'(c);
      end
    end
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_update_unit.md
FLAG_UPDATE_UNIT -- requirements
Module: flag_update_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named CLK and CLR.
REQ-002 CLK  input  1  system clock; state updates on posedge; downstream status register commits on negedge.
REQ-003 CLR  input  1  asynchronous active-low reset.
REQ-004 alu_valid  input  1  ALU result valid this cycle.
REQ-005 alu_s  input  1  instruction S bit: update flags.
REQ-006 alu_op  input  4  ARM data-processing opcode (0000 AND .. 1111 MVN).
REQ-007 alu_result  input  32  ALU result.
REQ-008 alu_cout  input  1  adder carry-out.
REQ-009 alu_ovf  input  1  adder overflow.
REQ-010 shf_cout  input  1  shifter carry-out.
REQ-011 alu_ready  output  1  update accepted when alu_valid && alu_ready.
REQ-012 msr_valid  input  1  MSR flag write request.
REQ-013 msr_flags  input  4  NZCV value for MSR.
REQ-014 psr_q  input  32  current status register contents.
REQ-015 cond  input  4  condition field of the instruction being decoded.
REQ-016 psr_d  output  32  data to status register D.
REQ-017 psr_le  output  1  active-low load enable to status register LE.
REQ-018 cond_pass  output  1  condition satisfied using forwarded flags.

Function
REQ-019 Arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN) SHALL produce N=result[31], Z=(result==0), C=alu_cout, V=alu_ovf.
REQ-020 Logical ops SHALL produce N, Z as above, C=shf_cout, and V=the current V (psr_q[28], or the staged V when PEND).
REQ-021 The FSM SHALL have two states: IDLE and PEND.
- IDLE -> PEND on an accepted update.
- PEND -> PEND on a new accepted update.
- PEND -> IDLE otherwise.
REQ-022 An accepted update SHALL be either msr_valid, or alu_valid && alu_s && alu_ready.
- An ALU request with alu_s=0 SHALL be accepted with no effect.
REQ-023 In PEND the block SHALL drive psr_le=0 and psr_d={staged NZCV, psr_q[27:0]}, for exactly one cycle per accepted update.
REQ-024 Latency SHALL be 1 posedge from acceptance to psr_le=0; the status register commits on the following negedge.
REQ-025 Simultaneous MSR and ALU requests: MSR SHALL win, and alu_ready SHALL be 0 that cycle.
- The ALU request is held by the producer and accepted on the next cycle, giving two consecutive PEND cycles.
REQ-026 alu_ready SHALL equal !msr_valid.
REQ-027 cond_pass SHALL evaluate the ARM condition codes against the forwarded flags.
- Forwarded flags = staged flags when in PEND, else psr_q[31:28].
- Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE; AL=1; 1111 (NV)=0.
REQ-028 cond_pass SHALL be combinational; no valid qualifier is applied.

Reset
REQ-029 While CLR=0 the block SHALL force: state=IDLE, staged NZCV=0000, psr_le=1, psr_d=0.
REQ-030 alu_ready SHALL follow !msr_valid during reset.
REQ-031 Reset asserted while in PEND SHALL cancel the pending commit immediately; no psr_le pulse occurs afterwards.
REQ-032 After CLR deasserts, the first posedge SHALL operate normally.

Structure
REQ-033 A shared package arm_pkg SHALL hold:
- opcode constants;
- condition-code constants;
- the FSM state enum;
- NZCV bit-index constants (N=31, Z=30, C=29, V=28).
REQ-034 Condition evaluation SHALL be a sub-module cond_eval (inputs cond and nzcv, output pass), reused by the branch unit.

Verification
REQ-035 ADD, S=1, result=0x00000000, cout=1, ovf=0 -> next cycle psr_le=0, psr_d[31:28]=0110; the cycle after, psr_le=1.
REQ-036 AND, S=1, result=0x80000000, shf_cout=1, psr_q[28]=1 -> psr_d[31:28]=1011.
REQ-037 Simultaneous msr_valid (flags 0001) and ALU SUB, S=1, result=0x5 held -> alu_ready=0; psr_d flags 0001, then 0010 on the next cycle; two consecutive psr_le=0 cycles.
REQ-038 Forwarding: stage Z=1 via CMP, cond=EQ (0000) in the PEND cycle while psr_q Z=0 -> cond_pass=1; cond=1111 -> cond_pass=0.
REQ-039 Assert CLR=0 during PEND -> psr_le=1 and psr_d=0 immediately; no commit after release.
REQ-040 ALU request with alu_s=0 -> psr_le stays 1 and state stays IDLE.
